// File: rtl/pointcloud_bram_responder.sv
// pointcloud_bram_responder: x/y/z 128-bit BRAM banks serving the DROR initiator, with a host point loader and done_irq.
// Define OUTLIER_COUNT_EN to add outlier_count, which counts RUN-state initiator writes to the x bank.
module pointcloud_bram_responder #(
   parameter int N = 16,
   parameter int DEPTH = 1024,
   parameter int READ_LATENCY = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [31:0]  addr_x,
   input  logic [31:0]  addr_y,
   input  logic [31:0]  addr_z,
   input  logic [127:0] write_in_x,
   input  logic [127:0] write_in_y,
   input  logic [127:0] write_in_z,
   output logic [127:0] read_out_x,
   output logic [127:0] read_out_y,
   output logic [127:0] read_out_z,
   input  logic         en_x,
   input  logic         en_y,
   input  logic         en_z,
   input  logic         rst_x,
   input  logic         rst_y,
   input  logic         rst_z,
   input  logic [15:0]  we_x,
   input  logic [15:0]  we_y,
   input  logic [15:0]  we_z,
   input  logic         load_start,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [N-1:0] load_x,
   input  logic [N-1:0] load_y,
   input  logic [N-1:0] load_z,
   input  logic         load_last,
   output logic [31:0]  point_count,
   output logic         busy,
   output logic         overflow,
   output logic         done_irq
`ifdef OUTLIER_COUNT_EN
   ,
   output logic [31:0]  outlier_count
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int LANES = 128 / N;
   localparam int LW = $clog2(LANES);
   localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, PUBLISH = 3'd2, RUN = 3'd3, DONE = 3'd4;

   logic [2:0] state;
   logic first;
   logic [AW:0] ptr;
   logic [LW-1:0] lane;
   logic [2:0][127:0] pk, nk, hdat, wdat, iwd;
   logic [2:0][15:0] hwe, wen, iwe;
   logic [2:0][31:0] iaddr;
   logic [2:0][AW-1:0] wadr;
   logic [2:0][N-1:0] lin;
   logic [2:0] ien, irst;
   logic host, full, xfer, flush, done_hit, unused_bits;

   assign iaddr = {addr_z, addr_y, addr_x};
   assign iwd = {write_in_z, write_in_y, write_in_x};
   assign iwe = {we_z, we_y, we_x};
   assign ien = {en_z, en_y, en_x};
   assign irst = {rst_z, rst_y, rst_x};
   assign lin = {load_z, load_y, load_x};
   assign unused_bits = ^{addr_x[31:AW], addr_y[31:AW], addr_z[31:AW]};

   assign host = state == LOAD || state == PUBLISH;
   assign busy = host;
   assign full = ptr == (AW+1)'(DEPTH);
   assign load_ready = state == LOAD && !first && !full;
   assign xfer = load_valid && load_ready && !load_start;
   assign flush = xfer && (lane == LW'(LANES - 1) || load_last);
   assign done_hit = state == RUN && en_z && we_z[0] && write_in_z[0] && addr_z[AW-1:0] == '0;

   // The host owns every write port while loading or publishing; the initiator keeps its reads.
   always_comb begin
      hwe = '0;
      for (int b = 0; b < 3; b++) nk[b] = pk[b] | (128'(lin[b]) << (N * int'(lane)));
      hdat = nk;
      if (state == LOAD && first) begin
         hwe[0] = '1;
         hwe[1] = '1;
         hdat = '0;
      end else if (flush) begin
         hwe = '1;
      end else if (state == PUBLISH) begin
         hwe = '1;
         hdat = {128'd0, 128'd1, {96'd0, point_count}};
      end
      for (int b = 0; b < 3; b++) begin
         wen[b] = host ? hwe[b] : ien[b] ? iwe[b] : '0;
         wadr[b] = !host ? iaddr[b][AW-1:0] : flush ? ptr[AW-1:0] : '0;
         wdat[b] = host ? hdat[b] : iwd[b];
      end
   end

   for (genvar g = 0; g < 3; g++) begin : bank
      logic [127:0] mem [0:DEPTH-1];
      logic [127:0] q;
      always_ff @(posedge clock) begin
         for (int i = 0; i < 16; i++)
            if (wen[g][i]) mem[wadr[g]][8*i +: 8] <= wdat[g][8*i +: 8];
      end
      if (READ_LATENCY == 2) begin : l2
         logic [127:0] d1;
         logic v1;
         always_ff @(posedge clock) begin
            if (reset) begin
               d1 <= '0;
               v1 <= 1'b0;
               q <= '0;
            end else begin
               v1 <= ien[g];
               if (ien[g]) d1 <= mem[iaddr[g][AW-1:0]];
               q <= irst[g] ? '0 : v1 ? d1 : q;
            end
         end
      end else begin : l1
         always_ff @(posedge clock) begin
            if (reset || irst[g]) q <= '0;
            else if (ien[g]) q <= mem[iaddr[g][AW-1:0]];
         end
      end
   end

   assign read_out_x = bank[0].q;
   assign read_out_y = bank[1].q;
   assign read_out_z = bank[2].q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         first <= 1'b0;
         ptr <= '0;
         lane <= '0;
         pk <= '0;
         point_count <= '0;
         overflow <= 1'b0;
         done_irq <= 1'b0;
`ifdef OUTLIER_COUNT_EN
         outlier_count <= '0;
`endif
      end else begin
         done_irq <= 1'b0;
         if (load_start) begin
            state <= LOAD;
            first <= 1'b1;
            ptr <= (AW+1)'(1);
            lane <= '0;
            pk <= '0;
            point_count <= '0;
            overflow <= 1'b0;
`ifdef OUTLIER_COUNT_EN
            outlier_count <= '0;
`endif
         end else begin
            case (state)
               LOAD: begin
                  first <= 1'b0;
                  if (xfer) begin
                     point_count <= &point_count ? point_count : point_count + 32'd1;
                     pk <= flush ? '0 : nk;
                     lane <= flush ? '0 : lane + LW'(1);
                     ptr <= ptr + (AW+1)'(flush);
                     if (load_last) state <= PUBLISH;
                  end else if (!first && full && load_valid) begin
                     overflow <= 1'b1;
                     if (load_last) state <= PUBLISH;
                  end
               end
               PUBLISH: state <= RUN;
               RUN: begin
                  if (done_hit) begin
                     done_irq <= 1'b1;
                     state <= DONE;
                  end
`ifdef OUTLIER_COUNT_EN
                  if (en_x && we_x != '0) outlier_count <= outlier_count + 32'd1;
`endif
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pointcloud_bram_responder.sv
// tb_pointcloud_bram_responder: drives a DEPTH=1024/latency-1 and a DEPTH=4/latency-2 responder with shared stimulus.
module tb_pointcloud_bram_responder;
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset;
   logic [31:0] addr_x, addr_y, addr_z;
   logic [127:0] write_in_x, write_in_y, write_in_z;
   logic en_x, en_y, en_z, rst_x, rst_y, rst_z;
   logic [15:0] we_x, we_y, we_z;
   logic load_start, load_valid, load_last;
   logic [15:0] load_x, load_y, load_z;
   logic [127:0] r1x, r1y, r1z, r2x, r2y, r2z;
   logic rdy1, rdy2, busy1, busy2, ov1, ov2, irq1, irq2;
   logic [31:0] pc1, pc2;
`ifdef OUTLIER_COUNT_EN
   logic [31:0] oc1, oc2;
`endif

   pointcloud_bram_responder #(.N(16), .DEPTH(1024), .READ_LATENCY(1)) u1 (
      .clock(clock), .reset(reset), .addr_x(addr_x), .addr_y(addr_y), .addr_z(addr_z),
      .write_in_x(write_in_x), .write_in_y(write_in_y), .write_in_z(write_in_z),
      .read_out_x(r1x), .read_out_y(r1y), .read_out_z(r1z),
      .en_x(en_x), .en_y(en_y), .en_z(en_z), .rst_x(rst_x), .rst_y(rst_y), .rst_z(rst_z),
      .we_x(we_x), .we_y(we_y), .we_z(we_z), .load_start(load_start), .load_valid(load_valid),
      .load_ready(rdy1), .load_x(load_x), .load_y(load_y), .load_z(load_z), .load_last(load_last),
      .point_count(pc1), .busy(busy1), .overflow(ov1), .done_irq(irq1)
`ifdef OUTLIER_COUNT_EN
      , .outlier_count(oc1)
`endif
   );

   pointcloud_bram_responder #(.N(16), .DEPTH(4), .READ_LATENCY(2)) u2 (
      .clock(clock), .reset(reset), .addr_x(addr_x), .addr_y(addr_y), .addr_z(addr_z),
      .write_in_x(write_in_x), .write_in_y(write_in_y), .write_in_z(write_in_z),
      .read_out_x(r2x), .read_out_y(r2y), .read_out_z(r2z),
      .en_x(en_x), .en_y(en_y), .en_z(en_z), .rst_x(rst_x), .rst_y(rst_y), .rst_z(rst_z),
      .we_x(we_x), .we_y(we_y), .we_z(we_z), .load_start(load_start), .load_valid(load_valid),
      .load_ready(rdy2), .load_x(load_x), .load_y(load_y), .load_z(load_z), .load_last(load_last),
      .point_count(pc2), .busy(busy2), .overflow(ov2), .done_irq(irq2)
`ifdef OUTLIER_COUNT_EN
      , .outlier_count(oc2)
`endif
   );

   typedef struct {
      int bank;
      logic [31:0] addr;
      logic [127:0] e1;
      logic [127:0] e2;
      string nm;
   } rvec_t;

   int checks = 0;
   int errors = 0;
   rvec_t t2[8];
   rvec_t t5[4];
   logic [127:0] v1, v2;
   localparam logic [127:0] A5 = {16{8'ha5}};
   localparam logic [127:0] XW1 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs;
      {addr_x, addr_y, addr_z} = '0;
      {write_in_x, write_in_y, write_in_z} = '0;
      {en_x, en_y, en_z, rst_x, rst_y, rst_z} = '0;
      {we_x, we_y, we_z} = '0;
      {load_start, load_valid, load_last} = '0;
      {load_x, load_y, load_z} = '0;
   endtask

   task automatic rd(input int b, input logic [31:0] a, output logic [127:0] o1, output logic [127:0] o2);
      addr_x = a;
      addr_y = a;
      addr_z = a;
      en_x = b == 0;
      en_y = b == 1;
      en_z = b == 2;
      tick;
      {en_x, en_y, en_z} = '0;
      tick;
      o1 = b == 0 ? r1x : b == 1 ? r1y : r1z;
      o2 = b == 0 ? r2x : b == 1 ? r2y : r2z;
   endtask

   task automatic push(input int i, input logic last);
      load_valid = 1'b1;
      load_x = 16'(i);
      load_y = 16'(i + 100);
      load_z = 16'(i + 200);
      load_last = last;
      for (int t = 0; t < 8 && !rdy1; t++) tick;
      chk("push_ready", 128'(rdy1), 128'd1);
      tick;
   endtask

   task automatic run_table(input rvec_t v);
      rd(v.bank, v.addr, v1, v2);
      chk({v.nm, "_d1"}, v1, v.e1);
      chk({v.nm, "_d2"}, v2, v.e2);
   endtask

   initial begin
      t2[0] = '{0, 32'd0, 128'd10, 128'd10, "hdr_x"};
      t2[1] = '{1, 32'd0, 128'd1, 128'd1, "hdr_y"};
      t2[2] = '{2, 32'd0, 128'd0, 128'd0, "hdr_z"};
      t2[3] = '{0, 32'd1, XW1, XW1, "x1"};
      t2[4] = '{0, 32'd2, 128'h0009_0008, 128'h0009_0008, "x2"};
      t2[5] = '{1, 32'd1, 128'h006b_006a_0069_0068_0067_0066_0065_0064, 128'h006b_006a_0069_0068_0067_0066_0065_0064, "y1"};
      t2[6] = '{2, 32'd2, 128'h00d1_00d0, 128'h00d1_00d0, "z2"};
      t2[7] = '{0, 32'd5, A5, XW1, "x5"};
      t5[0] = '{0, 32'd0, 128'd30, 128'd24, "ovf_hdr_x"};
      t5[1] = '{1, 32'd0, 128'd1, 128'd1, "ovf_hdr_y"};
      t5[2] = '{0, 32'd3, 128'h0017_0016_0015_0014_0013_0012_0011_0010, 128'h0017_0016_0015_0014_0013_0012_0011_0010, "ovf_x3"};
      t5[3] = '{0, 32'd5, A5, XW1, "blocked_x5"};

      idle_inputs;
      reset = 1'b1;
      tick;
      tick;
      reset = 1'b0;
      chk("rst_rx1", r1x, 128'd0);
      chk("rst_rx2", r2x, 128'd0);
      chk("rst_ready", 128'(rdy1), 128'd0);
      chk("rst_busy", 128'(busy1), 128'd0);
      chk("rst_ovf", 128'(ov2), 128'd0);
      chk("rst_irq", 128'(irq1), 128'd0);
      chk("rst_count", 128'(pc1), 128'd0);

      addr_x = 32'd5;
      write_in_x = A5;
      we_x = '1;
      en_x = 1'b1;
      tick;
      {we_x, en_x} = '0;
      write_in_x = '0;
      rst_x = 1'b1;
      tick;
      tick;
      rst_x = 1'b0;
      chk("clr_rx1", r1x, 128'd0);
      chk("clr_rx2", r2x, 128'd0);
      en_x = 1'b1;
      tick;
      en_x = 1'b0;
      chk("lat_edge1_d1", r1x, A5);
      chk("lat_edge1_d2", r2x, 128'd0);
      tick;
      chk("lat_edge2_d2", r2x, A5);
      chk("hold_d1", r1x, A5);
      rst_x = 1'b1;
      tick;
      rst_x = 1'b0;
      chk("rstx_d1", r1x, 128'd0);
      chk("rstx_d2", r2x, 128'd0);

      load_start = 1'b1;
      tick;
      load_start = 1'b0;
      chk("load_busy", 128'(busy1), 128'd1);
      chk("load_first_ready", 128'(rdy1), 128'd0);
      for (int i = 0; i < 10; i++) push(i, i == 9);
      {load_valid, load_last} = '0;
      chk("pub_busy", 128'(busy1), 128'd1);
      chk("pub_ready", 128'(rdy1), 128'd0);
      chk("pub_count_d1", 128'(pc1), 128'd10);
      chk("pub_count_d2", 128'(pc2), 128'd10);
      tick;
      chk("run_busy_d1", 128'(busy1), 128'd0);
      chk("run_busy_d2", 128'(busy2), 128'd0);
      for (int i = 0; i < 8; i++) run_table(t2[i]);

      addr_x = 32'd1;
      en_x = 1'b1;
      we_x = 16'h00ff;
      tick;
      {en_x, we_x} = '0;
      chk("rfirst_d1", r1x, XW1);
      tick;
      chk("rfirst_d2", r2x, XW1);
      rd(0, 32'd1, v1, v2);
      chk("bytemask_d1", v1, 128'h0007_0006_0005_0004_0000_0000_0000_0000);
      chk("bytemask_d2", v2, 128'h0007_0006_0005_0004_0000_0000_0000_0000);

      for (int k = 0; k < 2; k++) begin
         addr_z = 32'd0;
         en_z = 1'b1;
         we_z = 16'h00ff;
         write_in_z = 128'd1;
         tick;
         {en_z, we_z} = '0;
         write_in_z = '0;
         chk(k == 0 ? "irq_pulse_d1" : "irq_repeat_d1", 128'(irq1), 128'(k == 0));
         chk(k == 0 ? "irq_pulse_d2" : "irq_repeat_d2", 128'(irq2), 128'(k == 0));
         tick;
         chk("irq_fall_d1", 128'(irq1), 128'd0);
      end
      rd(2, 32'd0, v1, v2);
      chk("done_write_d1", v1, 128'd1);
      chk("done_write_d2", v2, 128'd1);

      load_start = 1'b1;
      tick;
      load_start = 1'b0;
      addr_x = 32'd5;
      en_x = 1'b1;
      we_x = '1;
      write_in_x = 128'hdead;
      tick;
      {en_x, we_x} = '0;
      write_in_x = '0;
      rd(1, 32'd0, v1, v2);
      chk("hdr_invalid_d1", v1, 128'd0);
      chk("hdr_invalid_d2", v2, 128'd0);
      for (int i = 0; i < 24; i++) push(i, 1'b0);
      chk("full_ready_d2", 128'(rdy2), 128'd0);
      chk("full_count_d2", 128'(pc2), 128'd24);
      chk("notfull_ready_d1", 128'(rdy1), 128'd1);
      for (int i = 24; i < 30; i++) push(i, i == 29);
      {load_valid, load_last} = '0;
      chk("ovf_d2", 128'(ov2), 128'd1);
      chk("ovf_d1", 128'(ov1), 128'd0);
      chk("ovf_count_d1", 128'(pc1), 128'd30);
      chk("ovf_count_d2", 128'(pc2), 128'd24);
      tick;
      for (int i = 0; i < 4; i++) run_table(t5[i]);

      load_start = 1'b1;
      tick;
      load_start = 1'b0;
      chk("abort_irq", 128'(irq1), 128'd0);
      chk("abort_busy", 128'(busy1), 128'd1);
      chk("abort_ovf_clr", 128'(ov2), 128'd0);
      tick;
      rd(1, 32'd0, v1, v2);
      chk("abort_hdr_d1", v1, 128'd0);
      chk("abort_hdr_d2", v2, 128'd0);
      chk("abort_no_irq", 128'(irq2), 128'd0);

      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("midload_rst_busy", 128'(busy1), 128'd0);
      chk("midload_rst_ready", 128'(rdy2), 128'd0);
      chk("midload_rst_count", 128'(pc1), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
